// File: rtl/aha_tlx_train_seq.sv
// TLX lane training sequencer: walks the latched lane mask in index order, running
// clear/start/wait attempts per lane with optional timeout and bounded retries.
module aha_tlx_train_seq #(
  parameter int NUM_LANES = 5,
  parameter int TMO_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 go_i,
  input  logic                 abort_i,
  input  logic [NUM_LANES-1:0] lane_mask_i,
  input  logic [TMO_W-1:0]     timeout_i,
  input  logic [1:0]           max_retry_i,
  input  logic [NUM_LANES-1:0] lane_done_i,
  output logic [NUM_LANES-1:0] lane_en_o,
  output logic [NUM_LANES-1:0] lane_ie_o,
  output logic [NUM_LANES-1:0] lane_start_o,
  output logic [NUM_LANES-1:0] lane_clear_o,
  output logic                 busy_o,
  output logic                 seq_done_o,
  output logic                 aborted_o,
  output logic [NUM_LANES-1:0] pass_mask_o,
  output logic [NUM_LANES-1:0] fail_mask_o,
  output logic [2:0]           cur_lane_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_CLR,
    ST_STRT,
    ST_WAIT,
    ST_FIN
  } state_e;

  localparam logic [TMO_W-1:0] TMO_ONE = 1;

  state_e               state_q, state_d;
  logic [2:0]           cur_lane_q, cur_lane_d;
  logic [1:0]           retry_q, retry_d;
  logic [TMO_W-1:0]     timer_q, timer_d;
  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [1:0]           max_retry_q, max_retry_d;
  logic [NUM_LANES-1:0] pass_q, pass_d;
  logic [NUM_LANES-1:0] fail_q, fail_d;
  logic                 aborted_q, aborted_d;

  logic [NUM_LANES-1:0] lane_sel;
  logic                 mask_hit;
  logic                 done_hit;
  logic                 at_end;
  logic                 timeout_hit;
  logic                 lane_active;

  // One-hot of the current lane; all zero once cur_lane has run past the last lane.
  always_comb begin
    lane_sel = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (cur_lane_q == 3'(i)) lane_sel[i] = 1'b1;
    end
  end

  assign mask_hit    = |(mask_q & lane_sel);
  assign done_hit    = |(lane_done_i & lane_sel);
  assign at_end      = (cur_lane_q == 3'(NUM_LANES));
  assign timeout_hit = (tmo_q != '0) && (timer_q == tmo_q - TMO_ONE);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    state_d     = state_q;
    cur_lane_d  = cur_lane_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    mask_d      = mask_q;
    tmo_d       = tmo_q;
    max_retry_d = max_retry_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    aborted_d   = aborted_q;

    unique case (state_q)
      ST_IDLE: begin
        if (go_i && !abort_i) begin
          mask_d      = lane_mask_i;
          tmo_d       = timeout_i;
          max_retry_d = max_retry_i;
          pass_d      = '0;
          fail_d      = '0;
          aborted_d   = 1'b0;
          retry_d     = '0;
          cur_lane_d  = '0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (at_end) begin
          state_d = ST_FIN;
        end else if (!mask_hit) begin
          cur_lane_d = cur_lane_q + 3'd1;
        end else begin
          state_d = ST_CLR;
        end
      end
      ST_CLR: state_d = ST_STRT;
      ST_STRT: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + TMO_ONE;
        // Done is checked before the timeout so a coincident done counts as a pass.
        if (done_hit) begin
          pass_d     = pass_q | lane_sel;
          retry_d    = '0;
          cur_lane_d = cur_lane_q + 3'd1;
          state_d    = ST_SCAN;
        end else if (timeout_hit) begin
          if (retry_q < max_retry_q) begin
            retry_d = retry_q + 2'd1;
            state_d = ST_CLR;
          end else begin
            fail_d     = fail_q | lane_sel;
            retry_d    = '0;
            cur_lane_d = cur_lane_q + 3'd1;
            state_d    = ST_SCAN;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any result update of the cycle so the current lane stays unmarked.
    if (abort_i && (state_q inside {ST_SCAN, ST_CLR, ST_STRT, ST_WAIT})) begin
      state_d    = ST_FIN;
      aborted_d  = 1'b1;
      pass_d     = pass_q;
      fail_d     = fail_q;
      retry_d    = retry_q;
      cur_lane_d = cur_lane_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cur_lane_q  <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      mask_q      <= '0;
      tmo_q       <= '0;
      max_retry_q <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_lane_q  <= cur_lane_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      mask_q      <= mask_d;
      tmo_q       <= tmo_d;
      max_retry_q <= max_retry_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      aborted_q   <= aborted_d;
    end
  end

  assign lane_active  = (state_q == ST_CLR) || (state_q == ST_STRT) || (state_q == ST_WAIT);
  assign lane_en_o    = lane_active ? lane_sel : '0;
  assign lane_ie_o    = lane_en_o;
  assign lane_start_o = (state_q == ST_STRT) ? lane_sel : '0;
  assign lane_clear_o = (state_q == ST_CLR) ? lane_sel : '0;
  assign busy_o       = (state_q != ST_IDLE);
  assign seq_done_o   = (state_q == ST_FIN);
  assign aborted_o    = aborted_q;
  assign pass_mask_o  = pass_q;
  assign fail_mask_o  = fail_q;
  assign cur_lane_o   = cur_lane_q;

endmodule

// File: tb/tb_aha_tlx_train_seq.sv
// Self-checking bench for aha_tlx_train_seq: per-lane responders follow a planned
// done delay per attempt; results and cycle counts come from an arithmetic model.
module tb_aha_tlx_train_seq;

  localparam int N  = 5;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          reset_i, go_i, abort_i;
  logic [N-1:0]  lane_mask_i, lane_done_i;
  logic [TW-1:0] timeout_i;
  logic [1:0]    max_retry_i;
  logic [N-1:0]  lane_en_o, lane_ie_o, lane_start_o, lane_clear_o;
  logic          busy_o, seq_done_o, aborted_o;
  logic [N-1:0]  pass_mask_o, fail_mask_o;
  logic [2:0]    cur_lane_o;

  always #5 clk = ~clk;

  aha_tlx_train_seq #(.NUM_LANES(N), .TMO_W(TW)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .go_i        (go_i),
    .abort_i     (abort_i),
    .lane_mask_i (lane_mask_i),
    .timeout_i   (timeout_i),
    .max_retry_i (max_retry_i),
    .lane_done_i (lane_done_i),
    .lane_en_o   (lane_en_o),
    .lane_ie_o   (lane_ie_o),
    .lane_start_o(lane_start_o),
    .lane_clear_o(lane_clear_o),
    .busy_o      (busy_o),
    .seq_done_o  (seq_done_o),
    .aborted_o   (aborted_o),
    .pass_mask_o (pass_mask_o),
    .fail_mask_o (fail_mask_o),
    .cur_lane_o  (cur_lane_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // plan[lane][attempt]: WAIT cycle (1-based after START) on which the lane raises done; 0 = never.
  int       plan [N][4];
  int       att [N];
  int       elapsed [N];
  int       dly [N];
  bit       armed [N];
  int       clr_cnt [N];
  int       strt_cnt [N];
  int       proto_err;
  logic [N-1:0] prev_clr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {28'd0, lane_en_o, lane_ie_o, lane_start_o, lane_clear_o, pass_mask_o,
            fail_mask_o, busy_o, seq_done_o, aborted_o, cur_lane_o};
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) plan[i][k] = 0;
  endtask

  task automatic resp_reset();
    for (int i = 0; i < N; i++) begin
      att[i] = 0; elapsed[i] = 0; dly[i] = 0; armed[i] = 1'b0;
      clr_cnt[i] = 0; strt_cnt[i] = 0;
    end
    proto_err = 0;
    prev_clr  = '0;
  endtask

  // Called once per falling edge: protocol watch, pulse counting and lane responders.
  task automatic step_mon();
    logic [N-1:0] nd;
    if (lane_ie_o !== lane_en_o) proto_err++;
    if ($countones(lane_en_o) > 1) proto_err++;
    if (((lane_start_o | lane_clear_o) & ~lane_en_o) != '0) proto_err++;
    if ((lane_en_o != '0) && (lane_en_o != (N'(1) << cur_lane_o))) proto_err++;
    if ((lane_start_o != '0) && (lane_start_o != prev_clr)) proto_err++;
    if (seq_done_o && ((lane_en_o | lane_start_o | lane_clear_o) != '0)) proto_err++;
    if (!busy_o && (lane_en_o != '0)) proto_err++;
    prev_clr = lane_clear_o;
    nd = '0;
    for (int i = 0; i < N; i++) begin
      clr_cnt[i]  += int'(lane_clear_o[i]);
      strt_cnt[i] += int'(lane_start_o[i]);
      if (lane_start_o[i]) begin
        armed[i]   = 1'b1;
        elapsed[i] = 0;
        dly[i]     = (att[i] < 4) ? plan[i][att[i]] : 0;
        att[i]++;
      end else if (armed[i]) begin
        elapsed[i]++;
        if (dly[i] != 0 && elapsed[i] == dly[i]) nd[i] = 1'b1;
      end
      // Done outside this lane's WAIT must be ignored, so sprinkle some there.
      if (!lane_en_o[i] || lane_start_o[i] || lane_clear_o[i])
        nd[i] = nd[i] | 1'($urandom_range(1, 0));
    end
    lane_done_i = nd;
  endtask

  // One full sequence; ab >= 0 pulses ABORT right after the first START on lane ab.
  task automatic run_seq(input logic [N-1:0] m, input int t, input int mr, input int ab,
                         input string tag);
    logic [N-1:0] exp_pass, exp_fail;
    int exp_att [N];
    int exp_busy, busy_cnt, cyc, d;
    bit stopped, done_seen, abort_sent;

    exp_pass = '0; exp_fail = '0; exp_busy = 1; stopped = 0;
    for (int i = 0; i < N; i++) exp_att[i] = 0;
    for (int i = 0; i < N; i++) begin
      exp_busy++;
      if (m[i]) begin
        if (i == ab) begin
          exp_att[i] = 1; exp_busy += 2; stopped = 1;
          break;
        end
        for (int k = 0; k <= mr; k++) begin
          d = plan[i][k];
          exp_att[i] = k + 1;
          if (d != 0 && (t == 0 || d <= t)) begin
            exp_pass[i] = 1'b1; exp_busy += 2 + d;
            break;
          end
          exp_busy += 2 + t;
          if (k == mr) exp_fail[i] = 1'b1;
        end
      end
    end
    if (!stopped) exp_busy++;

    resp_reset();
    @(negedge clk);
    lane_mask_i = m; timeout_i = TW'(t); max_retry_i = 2'(mr); go_i = 1'b1; abort_i = 1'b0;
    @(negedge clk);
    go_i = 1'b0;
    cyc = 0; busy_cnt = 0; done_seen = 0; abort_sent = 0;
    while (cyc < 4000) begin
      abort_i = 1'b0;
      step_mon();
      if (busy_o) busy_cnt++;
      if (seq_done_o) begin
        done_seen = 1;
        break;
      end
      if (ab >= 0 && !abort_sent && lane_start_o[ab]) begin
        abort_i = 1'b1; abort_sent = 1;
      end
      lane_mask_i = N'($urandom); timeout_i = TW'($urandom);
      max_retry_i = 2'($urandom); go_i = 1'($urandom_range(1, 0));
      cyc++;
      @(negedge clk);
    end
    go_i = 1'b0; abort_i = 1'b0;
    check({tag, " seq_done seen"}, 64'(done_seen), 64'd1);
    check({tag, " pass_mask"}, 64'(pass_mask_o), 64'(exp_pass));
    check({tag, " fail_mask"}, 64'(fail_mask_o), 64'(exp_fail));
    check({tag, " aborted"}, 64'(aborted_o), 64'(ab >= 0));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
    check({tag, " protocol errors"}, 64'(proto_err), 64'd0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s clear count lane%0d", tag, i), 64'(clr_cnt[i]), 64'(exp_att[i]));
      check($sformatf("%s start count lane%0d", tag, i), 64'(strt_cnt[i]), 64'(exp_att[i]));
    end
    @(negedge clk);
    lane_done_i = '0;
    check({tag, " idle after fin"}, 64'({busy_o, seq_done_o}), 64'd0);
    check({tag, " pass held"}, 64'(pass_mask_o), 64'(exp_pass));
  endtask

  initial begin
    int t, mr, ab, p, j;
    logic [N-1:0] m;
    bit found;

    reset_i = 1'b1; go_i = 1'b0; abort_i = 1'b0; lane_mask_i = '0;
    lane_done_i = '0; timeout_i = '0; max_retry_i = '0;
    clear_plan(); resp_reset();
    repeat (3) @(negedge clk);
    check("reset state", all_outs(), 64'd0);
    reset_i = 1'b0;

    clear_plan(); plan[0][0] = 3; plan[2][0] = 2;
    run_seq(5'b00101, 8, 0, -1, "two lanes pass");

    clear_plan();
    run_seq(5'b00010, 4, 2, -1, "retry then fail");

    clear_plan(); plan[0][1] = 5;
    run_seq(5'b00001, 5, 1, -1, "done on last wait cycle");

    clear_plan();
    run_seq(5'b00000, 3, 0, -1, "empty mask");

    clear_plan(); plan[0][0] = 2;
    run_seq(5'b10101, 6, 0, 2, "abort at lane2");

    // Timeout of 0 waits forever; abort must be the way out.
    clear_plan(); resp_reset();
    @(negedge clk);
    lane_mask_i = 5'b01000; timeout_i = '0; max_retry_i = '0; go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0;
    repeat (50) begin
      step_mon();
      @(negedge clk);
    end
    check("no-timeout still waiting", 64'(lane_en_o), 64'(5'b01000));
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0; lane_done_i = '0;
    check("abort lane_en off", 64'(lane_en_o), 64'd0);
    check("abort seq_done", 64'(seq_done_o), 64'd1);
    check("abort flag", 64'(aborted_o), 64'd1);
    check("abort masks", 64'({pass_mask_o, fail_mask_o}), 64'd0);
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort in idle ignored", 64'({busy_o, aborted_o}), 64'b01);

    // Reset in the middle of lane 3's WAIT, with GO raised alongside it.
    clear_plan(); resp_reset();
    for (int i = 0; i < 3; i++) plan[i][0] = 1;
    @(negedge clk);
    lane_mask_i = 5'b01111; timeout_i = TW'(10); max_retry_i = '0; go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0; found = 0;
    for (int c = 0; c < 200; c++) begin
      step_mon();
      if (lane_en_o[3] && !lane_start_o[3] && !lane_clear_o[3]) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("reached wait on lane3", 64'(found), 64'd1);
    check("pass before reset", 64'(pass_mask_o), 64'(5'b00111));
    reset_i = 1'b1; go_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0; go_i = 1'b0; lane_done_i = '0;
    check("outputs after mid-seq reset", all_outs(), 64'd0);
    clear_plan(); plan[0][0] = 2;
    run_seq(5'b00001, 4, 0, -1, "restart lane0");

    // GO together with ABORT in IDLE must not start anything.
    @(negedge clk);
    lane_mask_i = 5'b11111; go_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0; abort_i = 1'b0;
    check("go+abort idle busy", 64'(busy_o), 64'd0);
    check("go+abort idle results", 64'({pass_mask_o, fail_mask_o, aborted_o}), 64'({5'b00001, 5'b00000, 1'b0}));
    @(negedge clk);
    check("go+abort idle stays", 64'(busy_o), 64'd0);

    for (int r = 0; r < 30; r++) begin
      m  = N'($urandom);
      t  = $urandom_range(6, 0);
      mr = $urandom_range(3, 0);
      for (int i = 0; i < N; i++)
        for (int k = 0; k < 4; k++)
          plan[i][k] = (t == 0) ? $urandom_range(12, 1) : $urandom_range(t + 2, 0);
      ab = -1;
      if (m != '0 && $urandom_range(3, 0) == 0) begin
        p = $urandom_range(N - 1, 0);
        for (int s = 0; s < N; s++) begin
          j = (p + s) % N;
          if (m[j]) begin
            ab = j;
            break;
          end
        end
      end
      run_seq(m, t, mr, ab, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
